stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Shares the single hardware LIFO stack between two requesters: requester 0 is the call/return unit and requester 1 is the interrupt unit.
- Arbitrates requests, checks the stack FULL/EMPTY flags before issuing, and drives the stack's CE/nRW/DATA_IN for exactly one cycle per operation.
- Returns pop data plus a one-cycle ACK/ERR to the winning requester.
- Keeps a shadow occupancy count for status and debug.

Parameters:
- DATA_WIDTH, 8, width of stack words and requester data.
- DEPTH, 3, log2 of the stack entry count; must match the attached stack instance.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- REQ  input  2  per-requester request; bit i belongs to requester i.
- REQ_nRW  input  2  per-requester op: 1 = push, 0 = pop.
- REQ_DATA0  input  DATA_WIDTH  push data, requester 0.
- REQ_DATA1  input  DATA_WIDTH  push data, requester 1.
- ACK  output  2  one-cycle completion pulse per requester.
- ERR  output  1  qualifies ACK: operation rejected (overflow or underflow).
- RDATA  output  DATA_WIDTH  pop result, valid while ACK is high and ERR is low.
- STK_CE  output  1  stack chip enable.
- STK_nRW  output  1  stack op: 1 = write/push, 0 = read/pop.
- STK_DATA_IN  output  DATA_WIDTH  data to the stack.
- STK_DATA_OUT  input  DATA_WIDTH  stack registered output.
- STK_FULL  input  1  stack full flag.
- STK_EMPTY  input  1  stack empty flag.
- LEVEL  output  DEPTH+1  shadow occupancy, range 0..2**DEPTH.
- BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: ACK=0, ERR=0, RDATA=0, STK_CE=0, STK_nRW=0, STK_DATA_IN=0, LEVEL=0, BUSY=0, FSM in IDLE, round-robin pointer favours requester 0.
- FSM has four states: IDLE, ISSUE, DONE, REJECT.

IDLE:
- If no REQ bit is set, stay in IDLE.
- Otherwise pick a winner:
  - Only one bit set: that requester wins.
  - Both bits set: round-robin. The requester not granted last wins; the pointer updates on every grant.
- Latch the winner's index, op and data.
- Legality check: push with STK_FULL=1, or pop with STK_EMPTY=1, goes to REJECT. Otherwise go to ISSUE.

ISSUE (exactly 1 cycle):
- STK_CE=1; STK_nRW and STK_DATA_IN hold the latched op and data.
- Next state is DONE.

DONE (1 cycle):
- STK_CE=0. ACK[winner]=1, ERR=0.
- On a pop, RDATA takes STK_DATA_OUT.
- LEVEL increments on a push and decrements on a pop, saturating at 2**DEPTH and 0.
- Next state is IDLE.

REJECT (1 cycle):
- ACK[winner]=1, ERR=1, RDATA unchanged, the stack is not touched, LEVEL unchanged.
- Next state is IDLE.

Latency and throughput:
- Legal op: REQ sampled in cycle 0, STK_CE high in cycle 1, ACK in cycle 2.
- Illegal op: ACK with ERR in cycle 1.
- Peak rate is one operation every 3 cycles; the next arbitration happens in the IDLE cycle after DONE or REJECT.

Handshake rules:
- A requester holds REQ, REQ_nRW and its data stable until it sees its ACK.
- REQ sampled only in IDLE; changes at other times ignored.
- Once granted, the operation always runs to completion, even if REQ drops mid-operation.
- ACK is never asserted to both requesters in the same cycle.

Reset and flags:
- RST mid-operation returns the FSM to IDLE and clears all outputs the next cycle. The stack has its own reset; no STK_CE is issued while RST=1.
- The legality check uses STK_FULL and STK_EMPTY as sampled in IDLE. Flags are stable between operations because this block is the stack's only master.

Optional Feature:
- Macro: STACK_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 1 (interrupt) always wins a simultaneous request; the round-robin pointer logic is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Package stack_arb_pkg holds:
  - the FSM state typedef (IDLE, ISSUE, DONE, REJECT);
  - op constants OP_PUSH=1'b1 and OP_POP=1'b0;
  - requester index constants REQ_CALL=0 and REQ_IRQ=1.
- One sub-module, rr_arb2: a 2-input round-robin grant with a pointer, instantiated only when STACK_ARB_FIXED_PRIO_EN is undefined.
- Everything else stays flat.

Test Plan:
- Reset, then requester 0 pushes 8'hA5 with STK_FULL=0:
  - STK_CE=1 and STK_nRW=1 with STK_DATA_IN=8'hA5 in cycle 1;
  - ACK=2'b01, ERR=0 in cycle 2;
  - LEVEL=1.
- Requester 1 pops while the stack model returns 8'h3C (EMPTY=0, LEVEL=1): ACK=2'b10, RDATA=8'h3C, ERR=0, LEVEL=0.
- Pop with STK_EMPTY=1: no STK_CE ever; ACK[i]=1 with ERR=1 in cycle 1; LEVEL stays 0. Push with STK_FULL=1 behaves the same way.
- Both REQ held with pushes 8'h11 and 8'h22: grants alternate 0,1,0,1; the stack model receives 11,22,11,22; each ACK arrives 3 cycles apart. With STACK_ARB_FIXED_PRIO_EN defined, requester 1 wins every arbitration.
- Fill all 8 entries: LEVEL=8; the 9th push gets ERR=1. Drain all 8 entries: data comes back in LIFO order and LEVEL returns to 0.
- Assert RST during the ISSUE cycle of a push: the next cycle shows all outputs at reset values, BUSY=0, and no ACK.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the stack arbiter and its round-robin helper.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DONE   = 2'd2,
        REJECT = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    localparam int REQ_CALL = 0;
    localparam int REQ_IRQ  = 1;

    // One-hot acknowledge vector for a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. The pointer remembers the requester granted
// last; on a simultaneous request the other one wins. After reset the
// pointer favours requester 0.
module rr_arb2
    import stack_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic       o_grant
);

    logic r_last;

    // Grant index: the single requester, or the one not served last.
    always_comb begin
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~r_last;
        end else begin
            o_grant = i_req[REQ_IRQ];
        end
    end

    // Pointer moves on every accepted grant, single or contended.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_advance && (i_req != 2'b00)) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbiter sharing one LIFO stack between the call/return unit (requester 0)
// and the interrupt unit (requester 1). Drives one stack access per grant,
// returns ACK/ERR/RDATA and tracks a shadow occupancy count.
// Build option: define STACK_ARB_FIXED_PRIO_EN to give the interrupt unit
// fixed priority on simultaneous requests instead of round-robin.
//
// state  | meaning
// IDLE   | wait for a request, arbitrate, check FULL/EMPTY
// ISSUE  | STK_CE high for one cycle with latched op/data
// DONE   | ACK to winner, pop data and LEVEL updated
// REJECT | ACK with ERR, stack untouched
//
// STK_DATA_OUT is expected to present the current top-of-stack word; it is
// captured on the same edge the pop executes, so RDATA is valid together
// with ACK.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            REQ,
    input  logic [1:0]            REQ_nRW,
    input  logic [DATA_WIDTH-1:0] REQ_DATA0,
    input  logic [DATA_WIDTH-1:0] REQ_DATA1,
    output logic [1:0]            ACK,
    output logic                  ERR,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  STK_CE,
    output logic                  STK_nRW,
    output logic [DATA_WIDTH-1:0] STK_DATA_IN,
    input  logic [DATA_WIDTH-1:0] STK_DATA_OUT,
    input  logic                  STK_FULL,
    input  logic                  STK_EMPTY,
    output logic [DEPTH:0]        LEVEL,
    output logic                  BUSY
);

    localparam logic [DEPTH:0] LVL_MAX = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] LVL_ONE = {{DEPTH{1'b0}}, 1'b1};

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_win;
    logic                  r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_stk_ce;
    logic                  r_stk_nrw;
    logic [DATA_WIDTH-1:0] r_stk_din;
    logic [DEPTH:0]        r_level;
    logic                  r_busy;

    logic                  w_grant;
    logic                  w_win_nxt;
    logic                  w_op_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [1:0]            w_ack_nxt;
    logic                  w_err_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_ce_nxt;
    logic                  w_nrw_nxt;
    logic [DATA_WIDTH-1:0] w_din_nxt;
    logic [DEPTH:0]        w_level_nxt;
    logic                  w_req_op;
    logic [DATA_WIDTH-1:0] w_req_data;

`ifdef STACK_ARB_FIXED_PRIO_EN
    // Interrupt unit wins whenever it requests.
    assign w_grant = REQ[REQ_IRQ];
`else
    logic w_arb_adv;

    assign w_arb_adv = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_req     (REQ),
        .i_advance (w_arb_adv),
        .o_grant   (w_grant)
    );
`endif

    assign w_req_op   = REQ_nRW[w_grant];
    assign w_req_data = w_grant ? REQ_DATA1 : REQ_DATA0;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_ack_nxt   = 2'b00;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_ce_nxt    = 1'b0;
        w_nrw_nxt   = r_stk_nrw;
        w_din_nxt   = r_stk_din;
        w_level_nxt = r_level;

        case (r_state)
            IDLE: begin
                if (REQ != 2'b00) begin
                    w_win_nxt  = w_grant;
                    w_op_nxt   = w_req_op;
                    w_data_nxt = w_req_data;
                    if (((w_req_op == OP_PUSH) && STK_FULL) ||
                        ((w_req_op == OP_POP) && STK_EMPTY)) begin
                        w_state_nxt = REJECT;
                        w_ack_nxt   = req_onehot(w_grant);
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_ce_nxt    = 1'b1;
                        w_nrw_nxt   = w_req_op;
                        w_din_nxt   = w_req_data;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = DONE;
                w_ack_nxt   = req_onehot(r_win);
                if (r_op == OP_POP) begin
                    w_rdata_nxt = STK_DATA_OUT;
                    if (r_level != '0) begin
                        w_level_nxt = r_level - LVL_ONE;
                    end
                end else if (r_level != LVL_MAX) begin
                    w_level_nxt = r_level + LVL_ONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            REJECT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output and latched-request registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_win     <= 1'b0;
            r_op      <= OP_POP;
            r_data    <= '0;
            r_ack     <= 2'b00;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_stk_ce  <= 1'b0;
            r_stk_nrw <= 1'b0;
            r_stk_din <= '0;
            r_level   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_win     <= w_win_nxt;
            r_op      <= w_op_nxt;
            r_data    <= w_data_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_stk_ce  <= w_ce_nxt;
            r_stk_nrw <= w_nrw_nxt;
            r_stk_din <= w_din_nxt;
            r_level   <= w_level_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign ACK         = r_ack;
    assign ERR         = r_err;
    assign RDATA       = r_rdata;
    assign STK_CE      = r_stk_ce;
    assign STK_nRW     = r_stk_nrw;
    assign STK_DATA_IN = r_stk_din;
    assign LEVEL       = r_level;
    assign BUSY        = r_busy;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a small behavioural LIFO attached.
module tb_stack_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] REQ;
    logic [1:0] REQ_nRW;
    logic [7:0] REQ_DATA0;
    logic [7:0] REQ_DATA1;
    logic [1:0] ACK;
    logic       ERR;
    logic [7:0] RDATA;
    logic       STK_CE;
    logic       STK_nRW;
    logic [7:0] STK_DATA_IN;
    logic [7:0] STK_DATA_OUT;
    logic       STK_FULL;
    logic       STK_EMPTY;
    logic [3:0] LEVEL;
    logic       BUSY;

    stack_arbiter #(.DATA_WIDTH(8), .DEPTH(3)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ          (REQ),
        .REQ_nRW      (REQ_nRW),
        .REQ_DATA0    (REQ_DATA0),
        .REQ_DATA1    (REQ_DATA1),
        .ACK          (ACK),
        .ERR          (ERR),
        .RDATA        (RDATA),
        .STK_CE       (STK_CE),
        .STK_nRW      (STK_nRW),
        .STK_DATA_IN  (STK_DATA_IN),
        .STK_DATA_OUT (STK_DATA_OUT),
        .STK_FULL     (STK_FULL),
        .STK_EMPTY    (STK_EMPTY),
        .LEVEL        (LEVEL),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural 8-entry LIFO with optional flag/data override.
    logic [3:0] m_ptr;
    logic [7:0] m_mem [8];
    logic       ovr = 1'b0;
    logic [7:0] ovr_dout = 8'h00;
    logic       ovr_full = 1'b0;
    logic       ovr_empty = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_ptr <= 4'd0;
        end else if (STK_CE) begin
            if (STK_nRW) begin
                if (m_ptr < 4'd8) begin
                    m_mem[m_ptr[2:0]] <= STK_DATA_IN;
                    m_ptr <= m_ptr + 4'd1;
                end
            end else if (m_ptr > 4'd0) begin
                m_ptr <= m_ptr - 4'd1;
            end
        end
    end

    assign STK_DATA_OUT = ovr ? ovr_dout : ((m_ptr == 4'd0) ? 8'h00 : m_mem[3'(m_ptr - 4'd1)]);
    assign STK_FULL     = ovr ? ovr_full  : (m_ptr == 4'd8);
    assign STK_EMPTY    = ovr ? ovr_empty : (m_ptr == 4'd0);

    typedef struct {
        logic [1:0] ack;
        logic       err;
        logic [7:0] rdata;
        logic [3:0] level;
        int         cyc;
    } ack_t;

    typedef struct {
        logic       nrw;
        logic [7:0] din;
        int         cyc;
    } stk_t;

    ack_t ack_q[$];
    stk_t stk_q[$];
    logic [7:0] hist[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare stack accesses and acknowledges against the queues.
    initial begin
        ack_t a;
        stk_t s;
        forever begin
            @(negedge CLK);
            if (STK_CE === 1'b1) begin
                if (stk_q.size() == 0) begin
                    chk("unexpected_stk_ce", 32'(STK_CE), 32'd0);
                end else begin
                    s = stk_q.pop_front();
                    chk("stk_nrw", 32'(STK_nRW), 32'(s.nrw));
                    if (s.nrw) chk("stk_din", 32'(STK_DATA_IN), 32'(s.din));
                    chk("stk_ce_cycle", cyc, s.cyc);
                end
            end
            if (ACK !== 2'b00 && !$isunknown(ACK)) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ACK), 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack", 32'(ACK), 32'(a.ack));
                    chk("err", 32'(ERR), 32'(a.err));
                    chk("rdata", 32'(RDATA), 32'(a.rdata));
                    chk("level", 32'(LEVEL), 32'(a.level));
                    chk("ack_cycle", cyc, a.cyc);
                    chk("busy_at_ack", 32'(BUSY), 32'd1);
                end
            end
        end
    end

    // One single-requester operation; returns with the DUT back in IDLE.
    task automatic do_op(input int idx, input logic op, input logic [7:0] data,
                         input logic exp_err, input logic [7:0] exp_rd, input int exp_lvl);
        ack_t a;
        stk_t s;
        int   k;
        logic seen;
        k       = cyc;
        a.ack   = (idx == 1) ? 2'b10 : 2'b01;
        a.err   = exp_err;
        a.rdata = exp_rd;
        a.level = 4'(exp_lvl);
        a.cyc   = k + (exp_err ? 1 : 2);
        ack_q.push_back(a);
        if (!exp_err) begin
            s.nrw = op;
            s.din = data;
            s.cyc = k + 1;
            stk_q.push_back(s);
        end
        REQ[idx]     = 1'b1;
        REQ_nRW[idx] = op;
        if (idx == 0) REQ_DATA0 = data;
        else          REQ_DATA1 = data;
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(posedge CLK);
            #1;
            if (ACK[idx] === 1'b1) seen = 1'b1;
        end
        REQ[idx] = 1'b0;
        if (!seen) chk("ack_timeout", 32'(seen), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   32'(ACK), 32'd0);
        chk({tag, "_err"},   32'(ERR), 32'd0);
        chk({tag, "_rdata"}, 32'(RDATA), 32'd0);
        chk({tag, "_ce"},    32'(STK_CE), 32'd0);
        chk({tag, "_nrw"},   32'(STK_nRW), 32'd0);
        chk({tag, "_din"},   32'(STK_DATA_IN), 32'd0);
        chk({tag, "_level"}, 32'(LEVEL), 32'd0);
        chk({tag, "_busy"},  32'(BUSY), 32'd0);
    endtask

    initial begin
        ack_t       a;
        stk_t       s;
        int         k;
        int         w;
        logic [7:0] d;
        logic [7:0] last_rd;

        RST = 1'b1;
        REQ = 2'b00;
        REQ_nRW = 2'b00;
        REQ_DATA0 = 8'h00;
        REQ_DATA1 = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_reset_outputs("reset");

        // Push A5 from requester 0.
        do_op(0, 1'b1, 8'hA5, 1'b0, 8'h00, 1);

        // Pop by requester 1 with the stack returning 3C.
        ovr = 1'b1; ovr_dout = 8'h3C; ovr_full = 1'b0; ovr_empty = 1'b0;
        do_op(1, 1'b0, 8'h00, 1'b0, 8'h3C, 0);
        ovr = 1'b0;

        // Underflow and overflow rejects.
        do_op(0, 1'b0, 8'h00, 1'b1, 8'h3C, 0);
        ovr = 1'b1; ovr_full = 1'b1; ovr_empty = 1'b0;
        do_op(1, 1'b1, 8'h5A, 1'b1, 8'h3C, 0);
        ovr = 1'b0; ovr_full = 1'b0;

        // Both requesters held with pushes 11 and 22.
        k = cyc;
        for (int j = 0; j < 4; j++) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
            w = 1;
`else
            w = j % 2;
`endif
            a.ack   = (w == 1) ? 2'b10 : 2'b01;
            a.err   = 1'b0;
            a.rdata = 8'h3C;
            a.level = 4'(j + 1);
            a.cyc   = k + 2 + 3 * j;
            ack_q.push_back(a);
            s.nrw = 1'b1;
            s.din = (w == 1) ? 8'h22 : 8'h11;
            s.cyc = k + 1 + 3 * j;
            stk_q.push_back(s);
            hist.push_back(s.din);
        end
        REQ_DATA0 = 8'h11;
        REQ_DATA1 = 8'h22;
        REQ_nRW   = 2'b11;
        REQ       = 2'b11;
        repeat (11) @(posedge CLK);
        #1;
        REQ = 2'b00;
        @(posedge CLK);
        #1;

        // Fill to 8 entries, then overflow.
        for (int i = 0; i < 4; i++) begin
            d = 8'h80 + 8'(i);
            do_op(0, 1'b1, d, 1'b0, 8'h3C, 5 + i);
            hist.push_back(d);
        end
        do_op(1, 1'b1, 8'hEE, 1'b1, 8'h3C, 8);

        // Drain in LIFO order, then underflow.
        last_rd = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            last_rd = hist.pop_back();
            do_op(i % 2, 1'b0, 8'h00, 1'b0, last_rd, 7 - i);
        end
        do_op(1, 1'b0, 8'h00, 1'b1, last_rd, 0);

        // Reset while a push is in its ISSUE cycle.
        k = cyc;
        s.nrw = 1'b1;
        s.din = 8'h77;
        s.cyc = k + 1;
        stk_q.push_back(s);
        REQ_nRW[0] = 1'b1;
        REQ_DATA0  = 8'h77;
        REQ[0]     = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_reset_outputs("mid_rst");
        RST = 1'b0;
        REQ = 2'b00;
        repeat (4) @(posedge CLK);
        #1;
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("ack_q_left", ack_q.size(), 32'd0);
        chk("stk_q_left", stk_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
